axil_ptgen_master: RTL and testbench

- Parametrised AXI4-Lite master pattern generator and checker; successor to the fixed 4-word incrementing M00_AXI test master in the dvi IP.
- On an INIT_AXI_TXN rising edge it writes C_NUM_TRANS words starting at C_M_TARGET_BASE_ADDR, reads them back and compares them.
- Reports done, sticky error, saturating error count, first failing address and a response-timeout flag.
- Used in bring-up benches and on-chip self-test of AXI4-Lite slaves.

---
 rtl/axil_ptgen_master.sv | 226 ++++++++++++++++++++++
 tb/tb_axil_ptgen_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ptgen_master.sv
// AXI4-Lite master pattern generator/checker: writes a pattern run,
// reads it back, and reports mismatches, bad responses and stalls.
module axil_ptgen_master #(
  parameter int          C_M_AXI_ADDR_WIDTH   = 32,
  parameter int          C_M_AXI_DATA_WIDTH   = 32,
  parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h4000_0000,
  parameter int          C_NUM_TRANS          = 4,
  parameter int          C_ADDR_STRIDE        = C_M_AXI_DATA_WIDTH/8,
  parameter int          C_TIMEOUT_CYCLES     = 1024,
  parameter logic [31:0] C_LFSR_SEED          = 32'h0000_0001
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            INIT_AXI_TXN,
  input  logic [1:0]                      PATTERN_MODE,
  output logic                            BUSY,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic                            TIMEOUT,
  output logic [7:0]                      ERR_CNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   FIRST_ERR_ADDR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] BASE   = AW'(C_M_TARGET_BASE_ADDR);
  localparam logic [AW-1:0] STRIDE = AW'(C_ADDR_STRIDE);
  localparam logic [7:0]    LAST   = 8'(C_NUM_TRANS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(C_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t          state_q, state_d;
  logic            awv_q, awv_d;
  logic            wv_q, wv_d;
  logic            init_q, init_qq;
  logic [7:0]      idx_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     lfsr_q;
  logic [1:0]      mode_q;
  logic            err_q, tout_q;
  logic [7:0]      errcnt_q;
  logic [AW-1:0]   first_q;
  logic [TW-1:0]   timer_q;

  logic            init_edge, start, b_fire, r_fire, waiting;
  logic            last, err_evt;
  logic [31:0]     pat, addr32, lfsr_nx;
  logic [DW-1:0]   exp_data;

  assign init_edge = init_q & ~init_qq;
  assign last      = (idx_q == LAST);
  assign addr32    = 32'(addr_q);
  assign lfsr_nx   = {1'b0, lfsr_q[31:1]}
                   ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    pat = addr32;
    case (mode_q)
      2'b00:   pat = 32'(idx_q) + 32'd1;
      2'b01:   pat = 32'd1 << idx_q[4:0];
      2'b10:   pat = lfsr_q;
      default: pat = addr32;
    endcase
  end

  if (DW == 64) begin : g_w64
    assign exp_data = {~pat, pat};
  end else begin : g_w32
    assign exp_data = pat;
  end

  always_comb begin
    state_d = state_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    start   = 1'b0;
    b_fire  = 1'b0;
    r_fire  = 1'b0;
    waiting = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (init_edge) begin
          state_d = WR_ADDR;
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          start   = 1'b1;
        end
      end
      WR_ADDR: begin
        waiting = 1'b1;
        if (awv_q && M_AXI_AWREADY) awv_d = 1'b0;
        if (wv_q && M_AXI_WREADY)   wv_d  = 1'b0;
        if (!awv_d && !wv_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        waiting = 1'b1;
        if (M_AXI_BVALID) begin
          b_fire = 1'b1;
          if (last) begin
            state_d = RD_ADDR;
          end else begin
            state_d = WR_ADDR;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        waiting = 1'b1;
        if (M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        waiting = 1'b1;
        if (M_AXI_RVALID) begin
          r_fire  = 1'b1;
          state_d = last ? DONE : RD_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a bad RRESP with bad data is still a single error
  assign err_evt = (b_fire && M_AXI_BRESP != 2'b00)
                || (r_fire && (M_AXI_RRESP != 2'b00
                               || M_AXI_RDATA != exp_data));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      init_q   <= 1'b0;
      init_qq  <= 1'b0;
      idx_q    <= '0;
      addr_q   <= '0;
      lfsr_q   <= '0;
      mode_q   <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
      errcnt_q <= '0;
      first_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q <= state_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      init_q  <= INIT_AXI_TXN;
      init_qq <= init_q;
      if (state_d != state_q)
        timer_q <= '0;
      else if (waiting && timer_q != T_SAT)
        timer_q <= timer_q + TW'(1);
      if (waiting && state_d == state_q && timer_q == T_LAST) begin
        tout_q <= 1'b1;
        err_q  <= 1'b1;
      end
      if (start) begin
        idx_q    <= '0;
        addr_q   <= BASE;
        lfsr_q   <= C_LFSR_SEED;
        mode_q   <= PATTERN_MODE;
        err_q    <= 1'b0;
        tout_q   <= 1'b0;
        errcnt_q <= '0;
        first_q  <= '0;
      end else if (b_fire && last) begin
        idx_q  <= '0;
        addr_q <= BASE;
        lfsr_q <= C_LFSR_SEED;
      end else if (b_fire || r_fire) begin
        idx_q  <= idx_q + 8'd1;
        addr_q <= addr_q + STRIDE;
        lfsr_q <= lfsr_nx;
      end
      if (err_evt) begin
        err_q <= 1'b1;
        if (errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
        if (errcnt_q == 8'h00) first_q <= addr_q;
      end
    end
  end

  assign BUSY           = (state_q != IDLE) && (state_q != DONE);
  assign TXN_DONE       = (state_q == DONE);
  assign ERROR          = err_q;
  assign TIMEOUT        = tout_q;
  assign ERR_CNT        = errcnt_q;
  assign FIRST_ERR_ADDR = first_q;
  assign M_AXI_AWADDR   = addr_q;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_AWVALID  = awv_q;
  assign M_AXI_WDATA    = wv_q ? exp_data : '0;
  assign M_AXI_WSTRB    = {(DW/8){wv_q}};
  assign M_AXI_WVALID   = wv_q;
  assign M_AXI_BREADY   = (state_q == WR_RESP);
  assign M_AXI_ARADDR   = addr_q;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_ARVALID  = (state_q == RD_ADDR);
  assign M_AXI_RREADY   = (state_q == RD_DATA);

endmodule

// File: tb/tb_axil_ptgen_master.sv
// Directed bench: two pattern masters (32b/4 and 64b/200) against
// small RAM slaves with stall, error-response and corruption knobs.
module tb_axil_ptgen_master;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       init_a = 1'b0, init_b = 1'b0;
  logic [1:0] mode_a = 2'b00, mode_b = 2'b00;

  logic       busy_a, done_a, err_a, tout_a;
  logic [7:0] errcnt_a;
  logic [31:0] first_a, awa_a, ara_a, wd_a;
  logic [2:0] awp_a, arp_a;
  logic [3:0] wstrb_a;
  logic       awv_a, wv_a, br_a, arv_a, rr_a;

  logic       busy_b, done_b, err_b, tout_b;
  logic [7:0] errcnt_b;
  logic [31:0] first_b, awa_b, ara_b;
  logic [63:0] wd_b;
  logic [2:0] awp_b, arp_b;
  logic [7:0] wstrb_b;
  logic       awv_b, wv_b, br_b, arv_b, rr_b;

  logic [1:0]        awv, wv, br, arv, rr, awr;
  logic [1:0][31:0]  awa, ara;
  logic [1:0][63:0]  wdx;
  logic [1:0]        stall_aw = 2'b00;
  logic [1:0]        bad = 2'b00;
  int                corrupt = -1;

  logic [1:0]        awg, wg, bv, rv;
  logic [1:0][31:0]  aad, last_aw;
  logic [1:0][63:0]  wdt, rdx;
  logic [1:0][1:0]   bresp, rresp;
  logic [63:0]       mem [2][256];

  assign awv = {awv_b, awv_a};
  assign wv  = {wv_b, wv_a};
  assign br  = {br_b, br_a};
  assign arv = {arv_b, arv_a};
  assign rr  = {rr_b, rr_a};
  assign awa = {awa_b, awa_a};
  assign ara = {ara_b, ara_a};
  assign wdx = {wd_b, 32'h0, wd_a};
  assign awr = ~stall_aw;

  axil_ptgen_master dut_a (
    .ACLK(clk), .ARESETN(rstn),
    .INIT_AXI_TXN(init_a), .PATTERN_MODE(mode_a),
    .BUSY(busy_a), .TXN_DONE(done_a), .ERROR(err_a),
    .TIMEOUT(tout_a), .ERR_CNT(errcnt_a),
    .FIRST_ERR_ADDR(first_a),
    .M_AXI_AWADDR(awa_a), .M_AXI_AWPROT(awp_a),
    .M_AXI_AWVALID(awv_a), .M_AXI_AWREADY(awr[0]),
    .M_AXI_WDATA(wd_a), .M_AXI_WSTRB(wstrb_a),
    .M_AXI_WVALID(wv_a), .M_AXI_WREADY(1'b1),
    .M_AXI_BRESP(bresp[0]), .M_AXI_BVALID(bv[0]),
    .M_AXI_BREADY(br_a),
    .M_AXI_ARADDR(ara_a), .M_AXI_ARPROT(arp_a),
    .M_AXI_ARVALID(arv_a), .M_AXI_ARREADY(1'b1),
    .M_AXI_RDATA(rdx[0][31:0]), .M_AXI_RRESP(rresp[0]),
    .M_AXI_RVALID(rv[0]), .M_AXI_RREADY(rr_a)
  );

  axil_ptgen_master #(
    .C_M_AXI_DATA_WIDTH(64),
    .C_NUM_TRANS(200)
  ) dut_b (
    .ACLK(clk), .ARESETN(rstn),
    .INIT_AXI_TXN(init_b), .PATTERN_MODE(mode_b),
    .BUSY(busy_b), .TXN_DONE(done_b), .ERROR(err_b),
    .TIMEOUT(tout_b), .ERR_CNT(errcnt_b),
    .FIRST_ERR_ADDR(first_b),
    .M_AXI_AWADDR(awa_b), .M_AXI_AWPROT(awp_b),
    .M_AXI_AWVALID(awv_b), .M_AXI_AWREADY(awr[1]),
    .M_AXI_WDATA(wd_b), .M_AXI_WSTRB(wstrb_b),
    .M_AXI_WVALID(wv_b), .M_AXI_WREADY(1'b1),
    .M_AXI_BRESP(bresp[1]), .M_AXI_BVALID(bv[1]),
    .M_AXI_BREADY(br_b),
    .M_AXI_ARADDR(ara_b), .M_AXI_ARPROT(arp_b),
    .M_AXI_ARVALID(arv_b), .M_AXI_ARREADY(1'b1),
    .M_AXI_RDATA(rdx[1]), .M_AXI_RRESP(rresp[1]),
    .M_AXI_RVALID(rv[1]), .M_AXI_RREADY(rr_b)
  );

  function automatic int sidx(input int k, input logic [31:0] a);
    return (k == 0) ? int'(a[9:2]) : int'(a[10:3]);
  endfunction

  // zero-wait RAM slaves; AW and W may arrive in either order
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awg <= '0;
      wg  <= '0;
      bv  <= '0;
      rv  <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (awv[k] && awr[k]) begin
          awg[k] <= 1'b1;
          aad[k] <= awa[k];
        end
        if (wv[k]) begin
          wg[k]  <= 1'b1;
          wdt[k] <= wdx[k];
        end
        if ((awg[k] || (awv[k] && awr[k]))
            && (wg[k] || wv[k]) && !bv[k]) begin
          mem[k][sidx(k, awg[k] ? aad[k] : awa[k])]
            <= wg[k] ? wdt[k] : wdx[k];
          last_aw[k] <= awg[k] ? aad[k] : awa[k];
          bv[k]      <= 1'b1;
          bresp[k]   <= bad[k] ? 2'b10 : 2'b00;
          awg[k]     <= 1'b0;
          wg[k]      <= 1'b0;
        end
        if (bv[k] && br[k]) bv[k] <= 1'b0;
        if (arv[k] && !rv[k]) begin
          rv[k]    <= 1'b1;
          rresp[k] <= bad[k] ? 2'b10 : 2'b00;
          rdx[k]   <= mem[k][sidx(k, ara[k])]
                    ^ ((k == 0 && sidx(k, ara[k]) == corrupt)
                       ? 64'h1 : 64'h0);
        end
        if (rv[k] && rr[k]) rv[k] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit which, input logic [1:0] m);
    @(negedge clk);
    if (which) begin
      mode_b = m;
      init_b = 1'b1;
    end else begin
      mode_a = m;
      init_a = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    init_a = 1'b0;
    init_b = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int maxc,
                           input string tag);
    int n = 0;
    while (!(which ? done_b : done_a) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'h0, (which ? done_b : done_a)}, 64'h1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_flags",
          {55'h0, busy_a, done_a, err_a, tout_a,
           awv_a, wv_a, br_a, arv_a, rr_a}, 64'h0);
    check("rst_cnt", {24'h0, errcnt_a, first_a}, 64'h0);
    check("rst_bus", {awa_a, wd_a}, 64'h0);
    check("rst_strb", {60'h0, wstrb_a}, 64'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // mode 00 with exact latency
    mode_a = 2'b00;
    init_a = 1'b1;
    repeat (2) @(negedge clk);
    init_a = 1'b0;
    check("t1_awaddr", {32'h0, awa_a}, 64'h4000_0000);
    check("t1_wdata", {32'h0, wd_a}, 64'h1);
    check("t1_valid_strb",
          {57'h0, awv_a, wv_a, busy_a, wstrb_a}, 64'h7F);
    check("t1_prot", {52'h0, awp_a, arp_a, awp_b, arp_b}, 64'h0);
    repeat (15) @(negedge clk);
    check("t1_done_c16", {63'h0, done_a}, 64'h0);
    @(negedge clk);
    check("t1_done_c17", {62'h0, done_a, busy_a}, 64'h2);
    check("t1_err", {55'h0, err_a, errcnt_a}, 64'h0);
    check("t1_mem0", mem[0][0], 64'h1);
    check("t1_mem1", mem[0][1], 64'h2);
    check("t1_mem2", mem[0][2], 64'h3);
    check("t1_mem3", mem[0][3], 64'h4);
    check("t1_lastaw", {32'h0, last_aw[0]}, 64'h4000_000C);

    // LFSR with a corrupted read at index 2
    corrupt = 2;
    pulse(1'b0, 2'b10);
    wait_done(1'b0, 100, "t3_done_bound");
    corrupt = -1;
    check("t3_lfsr1", mem[0][1], 64'h8020_0003);
    check("t3_lfsr2", mem[0][2], 64'hC030_0002);
    check("t3_lfsr3", mem[0][3], 64'h6018_0001);
    check("t3_errcnt", {56'h0, errcnt_a}, 64'h1);
    check("t3_first", {32'h0, first_a}, 64'h4000_0008);
    check("t3_flags", {62'h0, err_a, tout_a}, 64'h2);

    // AWREADY withheld: timeout after 1024 waiting cycles
    stall_aw[0] = 1'b1;
    mode_a = 2'b00;
    init_a = 1'b1;
    repeat (2) @(negedge clk);
    init_a = 1'b0;
    repeat (1023) @(negedge clk);
    check("t5_tout_c1024", {62'h0, tout_a, awv_a}, 64'h1);
    @(negedge clk);
    check("t5_tout_c1025", {61'h0, tout_a, err_a, awv_a}, 64'h7);
    check("t5_cnt", {56'h0, errcnt_a}, 64'h0);
    repeat (74) @(negedge clk);
    stall_aw[0] = 1'b0;
    wait_done(1'b0, 100, "t5_done_bound");
    check("t5_end", {53'h0, tout_a, err_a, errcnt_a}, 64'h300);
    pulse(1'b0, 2'b00);
    wait_done(1'b0, 100, "t5b_done_bound");
    check("t5b_clear", {53'h0, tout_a, err_a, errcnt_a}, 64'h0);

    // 64-bit walking one over 200 words
    pulse(1'b1, 2'b01);
    wait_done(1'b1, 1000, "t2_done_bound");
    check("t2_w0", mem[1][0], 64'hFFFF_FFFE_0000_0001);
    check("t2_w31", mem[1][31], 64'h7FFF_FFFF_8000_0000);
    check("t2_w33", mem[1][33], 64'hFFFF_FFFD_0000_0002);
    check("t2_w199", mem[1][199], 64'hFFFF_FF7F_0000_0080);
    check("t2_err", {47'h0, err_b, tout_b, errcnt_b, wstrb_b},
          64'h0);

    // SLVERR on every response saturates the counter
    bad[1] = 1'b1;
    pulse(1'b1, 2'b00);
    wait_done(1'b1, 1000, "t4_done_bound");
    bad[1] = 1'b0;
    check("t4_errcnt", {56'h0, errcnt_b}, 64'hFF);
    check("t4_first", {32'h0, first_b}, 64'h4000_0000);
    check("t4_flags", {62'h0, err_b, tout_b}, 64'h2);

    // INIT while busy is ignored; async reset in RD_DATA
    mode_a = 2'b00;
    init_a = 1'b1;
    repeat (2) @(negedge clk);
    init_a = 1'b0;
    repeat (3) @(negedge clk);
    init_a = 1'b1;
    @(negedge clk);
    init_a = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_rd_data", {61'h0, rr_a, arv_a, busy_a}, 64'h5);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_flags",
          {55'h0, busy_a, done_a, err_a, tout_a,
           awv_a, wv_a, br_a, arv_a, rr_a}, 64'h0);
    check("t6_rst_bus", {ara_a, wd_a}, 64'h0);
    check("t6_rst_misc", {52'h0, wstrb_a, errcnt_a}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    pulse(1'b0, 2'b11);
    wait_done(1'b0, 100, "t6_done_bound");
    check("t6_clean", {55'h0, err_a, errcnt_a}, 64'h0);
    check("t6_mem2", mem[0][2], 64'h4000_0008);
    check("t6_mem3", mem[0][3], 64'h4000_000C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
